tmr_recovery_ctrl: RTL

Fault-recovery controller for the triple-redundant RISC-V core. It consumes the voter's 3-bit pairwise agreement state and the voted PC/MemWrite, and keeps a short history of PCs on which all three cores agreed. On a single-core disagreement it requests a resync of the faulty core. On loss of majority it stalls all cores and issues a rollback to a checkpoint PC. It sits between the voter and the three core copies.

---
 rtl/tmr_recovery_ctrl_if.sv | 28 ++
 rtl/tmr_recovery_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tmr_recovery_ctrl_if.sv
// Voter-side signal bundle for the TMR fault-recovery controller.
// The master drives voter results; the slave (controller) drives recovery commands.
interface tmr_recovery_ctrl_if;
  logic [2:0]  voter_state;
  logic [31:0] pc_voted;
  logic        mem_write_in;
  logic        mem_write_out;
  logic        stall;
  logic [2:0]  resync_req;
  logic        rollback_valid;
  logic [31:0] rollback_pc;
  logic [15:0] single_fault_cnt;
  logic [15:0] rollback_cnt;
  logic        fatal;
  logic [1:0]  ctrl_state;

  modport master (
    output voter_state, pc_voted, mem_write_in,
    input  mem_write_out, stall, resync_req, rollback_valid, rollback_pc,
           single_fault_cnt, rollback_cnt, fatal, ctrl_state
  );

  modport slave (
    input  voter_state, pc_voted, mem_write_in,
    output mem_write_out, stall, resync_req, rollback_valid, rollback_pc,
           single_fault_cnt, rollback_cnt, fatal, ctrl_state
  );
endinterface

// File: rtl/tmr_recovery_ctrl.sv
// Fault-recovery controller for a triple-redundant core: resyncs a single faulty
// core, rolls back to the oldest agreed PC on loss of majority, halts on repeated failure.
module tmr_recovery_ctrl #(
  parameter int unsigned DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned RESYNC_CYCLES   = 4,
  parameter int unsigned ROLLBACK_CYCLES = 8,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic              clk,
  input  logic              rst_in,
  tmr_recovery_ctrl_if.slave bus
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned RW   = $clog2(MAX_RETRY + 1);
  localparam int unsigned MAXC = (RESYNC_CYCLES > ROLLBACK_CYCLES) ? RESYNC_CYCLES : ROLLBACK_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_RESYNC   = 2'b01,
    ST_ROLLBACK = 2'b10,
    ST_HALT     = 2'b11
  } state_t;

  state_t         r_state;
  logic [31:0]    r_hist [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic [RW-1:0]  r_retry;
  logic [TW-1:0]  r_timer;
  logic           r_stall;
  logic [2:0]     r_resync_req;
  logic           r_rollback_valid;
  logic [31:0]    r_rollback_pc;
  logic [15:0]    r_sfc;
  logic [15:0]    r_rbc;
  logic           r_fatal;

  logic           w_agree;
  logic           w_single;
  logic [2:0]     w_faulty;
  logic [PW-1:0]  w_oldest_idx;

  // Two-bit agreement patterns are impossible for a consistent voter and fall into no-majority.
  always_comb begin
    w_agree  = (bus.voter_state == 3'b111);
    w_single = 1'b1;
    w_faulty = '0;
    unique case (bus.voter_state)
      3'b100:  w_faulty = 3'b100;
      3'b010:  w_faulty = 3'b001;
      3'b001:  w_faulty = 3'b010;
      default: w_single = 1'b0;
    endcase
  end

  // When full, count's low bits are zero so the oldest entry is the one about to be overwritten.
  assign w_oldest_idx = r_wr_ptr - r_count[PW-1:0];

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state          <= ST_RUN;
      for (int unsigned i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_retry          <= '0;
      r_timer          <= '0;
      r_stall          <= 1'b0;
      r_resync_req     <= '0;
      r_rollback_valid <= 1'b0;
      r_rollback_pc    <= '0;
      r_sfc            <= '0;
      r_rbc            <= '0;
      r_fatal          <= 1'b0;
    end else begin
      r_resync_req     <= '0;
      r_rollback_valid <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (w_agree) begin
            r_hist[r_wr_ptr] <= bus.pc_voted;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
            if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
            r_retry          <= '0;
          end else if (w_single) begin
            r_state      <= ST_RESYNC;
            r_stall      <= 1'b1;
            r_resync_req <= w_faulty;
            r_timer      <= TW'(RESYNC_CYCLES - 1);
            if (r_sfc != '1) r_sfc <= r_sfc + 16'd1;
          end else begin
            r_rollback_pc <= (r_count == '0) ? RESET_PC : r_hist[w_oldest_idx];
            r_count       <= '0;
            r_stall       <= 1'b1;
            if (r_retry == RW'(MAX_RETRY - 1)) begin
              r_state <= ST_HALT;
              r_fatal <= 1'b1;
            end else begin
              r_state          <= ST_ROLLBACK;
              r_retry          <= r_retry + RW'(1);
              r_rollback_valid <= 1'b1;
              r_timer          <= TW'(ROLLBACK_CYCLES - 1);
              if (r_rbc != '1) r_rbc <= r_rbc + 16'd1;
            end
          end
        end
        ST_RESYNC, ST_ROLLBACK: begin
          if (r_timer == '0) begin
            r_state <= ST_RUN;
            r_stall <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign bus.mem_write_out    = bus.mem_write_in & (r_state == ST_RUN) & w_agree;
  assign bus.stall            = r_stall;
  assign bus.resync_req       = r_resync_req;
  assign bus.rollback_valid   = r_rollback_valid;
  assign bus.rollback_pc      = r_rollback_pc;
  assign bus.single_fault_cnt = r_sfc;
  assign bus.rollback_cnt     = r_rbc;
  assign bus.fatal            = r_fatal;
  assign bus.ctrl_state       = r_state;

endmodule
